// File: rtl/frame_deserializer_if.sv
// Bundles the frame deserializer's input strobes and its valid/ready output word.
// The slave side is the deserializer, the master side is whoever drives and consumes it.
interface frame_deserializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             clk_en;
    logic             frm_start;
    logic             bit_valid;
    logic             ser_in;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic [CNT_W-1:0] out_nbits;
    logic             ovf;
    logic             busy;

    modport slave (
        input  clk_en, frm_start, bit_valid, ser_in, out_ready,
        output out_data, out_valid, out_last, out_nbits, ovf, busy
    );

    modport master (
        output clk_en, frm_start, bit_valid, ser_in, out_ready,
        input  out_data, out_valid, out_last, out_nbits, ovf, busy
    );
endinterface

// File: rtl/frame_deserializer.sv
// Packs detector payload bits MSB-first into WIDTH-bit words behind a single-entry
// valid/ready holding register. Frame start comes from frm_start, bit strobes from bit_valid.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no frame open, waiting for frm_start
//   S_ARM     | frame opened, waiting for the first payload bit
//   S_COLLECT | shifting payload bits; bit_valid low closes the frame
module frame_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    frame_deserializer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_COLLECT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [CNT_W-1:0] r_out_nbits;
    logic             r_ovf;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_full;
    logic [WIDTH-1:0] w_mask;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic [CNT_W-1:0] w_push_nbits;
    logic             w_push_last;

    assign w_shift_nxt = {r_shift[WIDTH-2:0], bus.ser_in};
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_full      = (w_cnt_inc == CNT_W'(WIDTH));
    // Stale bits from an earlier full word sit above the partial count; mask them off.
    assign w_mask      = ~({WIDTH{1'b1}} << r_cnt);

    always_comb begin
        w_push       = 1'b0;
        w_push_data  = '0;
        w_push_nbits = '0;
        w_push_last  = 1'b0;
        if (bus.clk_en && (r_state == S_COLLECT) && !bus.frm_start) begin
            if (bus.bit_valid) begin
                if (w_full) begin
                    w_push       = 1'b1;
                    w_push_data  = w_shift_nxt;
                    w_push_nbits = CNT_W'(WIDTH);
                end
            end else begin
                w_push       = 1'b1;
                w_push_data  = r_shift & w_mask;
                w_push_nbits = r_cnt;
                w_push_last  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_nbits <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (bus.clk_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.frm_start) begin
                            r_state <= S_ARM;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    S_ARM: begin
                        if (bus.frm_start) begin
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end else if (bus.bit_valid) begin
                            r_state <= S_COLLECT;
                            r_shift <= {{(WIDTH-1){1'b0}}, bus.ser_in};
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                    S_COLLECT: begin
                        if (bus.frm_start) begin
                            r_state <= S_ARM;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end else if (bus.bit_valid) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= w_full ? '0 : w_cnt_inc;
                        end else begin
                            r_state <= S_IDLE;
                            r_shift <= '0;
                            r_cnt   <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // Handshake runs every edge; a push into a full, stalled register is dropped.
            if (w_push) begin
                if (!r_out_valid || bus.out_ready) begin
                    r_out_data  <= w_push_data;
                    r_out_nbits <= w_push_nbits;
                    r_out_last  <= w_push_last;
                    r_out_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_nbits = r_out_nbits;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench: table-driven frames feed an expected-word queue that a
// negedge monitor pops on every accepted word; corner cases are hand-written.
module tb_frame_deserializer;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    frame_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    frame_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [15:0] bits;
        int          nw;
        logic [23:0] d;
        logic [11:0] n;
        logic [2:0]  l;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [3:0] n;
        logic       l;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.out_valid), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data",  32'(bus.out_data),  32'(e.d));
                check("word_nbits", 32'(bus.out_nbits), 32'(e.n));
                check("word_last",  32'(bus.out_last),  32'(e.l));
            end
        end
    end

    task automatic drive_cycle(input logic fs, input logic bv, input logic si, input bit alt);
        bus.frm_start = fs;
        bus.bit_valid = bv;
        bus.ser_in    = si;
        bus.clk_en    = 1'b1;
        @(posedge clk); #1;
        if (alt) begin
            bus.clk_en = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic push_expected(input vec_t v);
        for (int k = 0; k < v.nw; k++) begin
            exp_t e;
            e.d = v.d[8*k +: 8];
            e.n = v.n[4*k +: 4];
            e.l = v.l[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bits(input int nb, input logic [15:0] bits, input bit alt);
        for (int i = 0; i < nb; i++) drive_cycle(1'b0, 1'b1, bits[nb-1-i], alt);
    endtask

    task automatic idle_cycles(input int n);
        bus.frm_start = 1'b0;
        bus.bit_valid = 1'b0;
        bus.ser_in    = 1'b0;
        bus.clk_en    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 60) begin
            @(posedge clk); #1;
            budget++;
        end
        check({nm, "_drained"}, 32'(exp_q.size()), 32'(0));
        exp_q.delete();
    endtask

    task automatic send_frame(input vec_t v, input bit alt, input string nm);
        push_expected(v);
        drive_cycle(1'b1, 1'b0, 1'b0, alt);
        send_bits(v.nb, v.bits, alt);
        drive_cycle(1'b0, 1'b0, 1'b0, alt);
        if (!alt) begin
            check({nm, "_last_latency"}, 32'({bus.out_valid, bus.out_last}), 32'(2'b11));
        end
        idle_cycles(2);
        drain(nm);
        check({nm, "_busy"}, 32'(bus.busy), 32'(0));
        check({nm, "_ovf"},  32'(bus.ovf),  32'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs[0] = '{16, 16'hA53C, 3, {8'h00, 8'h3C, 8'hA5}, {4'd0, 4'd8, 4'd8}, 3'b100};
        vecs[1] = '{11, 16'h0785, 2, {8'h00, 8'h05, 8'hF0}, {4'd0, 4'd3, 4'd8}, 3'b010};
        vecs[2] = '{ 8, 16'h0081, 2, {8'h00, 8'h00, 8'h81}, {4'd0, 4'd0, 4'd8}, 3'b010};
        vecs[3] = '{ 1, 16'h0001, 1, {8'h00, 8'h00, 8'h01}, {4'd0, 4'd0, 4'd1}, 3'b001};
        vecs[4] = '{ 7, 16'h0059, 1, {8'h00, 8'h00, 8'h59}, {4'd0, 4'd0, 4'd7}, 3'b001};
        vecs[5] = '{ 9, 16'h01FE, 2, {8'h00, 8'h00, 8'hFF}, {4'd0, 4'd1, 4'd8}, 3'b010};

        bus.clk_en = 1'b1; bus.frm_start = 1'b0; bus.bit_valid = 1'b0;
        bus.ser_in = 1'b0; bus.out_ready = 1'b1;
        #12;
        check("rst_valid", 32'(bus.out_valid), 32'(0));
        check("rst_data",  32'(bus.out_data),  32'(0));
        check("rst_busy",  32'(bus.busy),      32'(0));
        check("rst_ovf",   32'(bus.ovf),       32'(0));
        @(negedge clk); rst = 1'b1;
        idle_cycles(2);

        for (int t = 0; t < 6; t++) send_frame(vecs[t], 1'b0, $sformatf("vec%0d", t));

        // clk_en alternating with every input held two cycles
        send_frame(vecs[0], 1'b1, "clken_alt");

        // abort after 4 bits, then a clean 0x3C frame
        v = '{8, 16'h003C, 2, {8'h00, 8'h00, 8'h3C}, {4'd0, 4'd0, 4'd8}, 3'b010};
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(4, 16'h000F, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_no_word", 32'(bus.out_valid), 32'(0));
        check("abort_busy",    32'(bus.busy),      32'(1));
        push_expected(v);
        send_bits(8, 16'h003C, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(2);
        drain("abort");

        // stalled consumer: first word held, later pushes dropped
        bus.out_ready = 1'b0;
        v = '{16, 16'hA53C, 1, {8'h00, 8'h00, 8'hA5}, {4'd0, 4'd0, 4'd8}, 3'b000};
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(15, 16'h529E, 1'b0);
        check("stall_ovf_pre", 32'(bus.ovf), 32'(0));
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("stall_ovf_16", 32'(bus.ovf), 32'(1));
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);
        check("stall_valid", 32'(bus.out_valid), 32'(1));
        check("stall_data",  32'(bus.out_data),  32'(8'hA5));
        check("stall_nbits", 32'(bus.out_nbits), 32'(8));
        check("stall_last",  32'(bus.out_last),  32'(0));
        push_expected(v);
        bus.out_ready = 1'b1;
        idle_cycles(2);
        drain("stall");
        check("stall_empty_after", 32'(bus.out_valid), 32'(0));
        check("stall_ovf_sticky",  32'(bus.ovf),       32'(1));

        // asynchronous reset mid-frame
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(5, 16'h0015, 1'b0);
        check("prerst_busy", 32'(bus.busy), 32'(1));
        #2 rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid), 32'(0));
        check("rst_mid_data",  32'(bus.out_data),  32'(0));
        check("rst_mid_nbits", 32'(bus.out_nbits), 32'(0));
        check("rst_mid_last",  32'(bus.out_last),  32'(0));
        check("rst_mid_ovf",   32'(bus.ovf),       32'(0));
        check("rst_mid_busy",  32'(bus.busy),      32'(0));
        @(negedge clk); rst = 1'b1;
        idle_cycles(1);
        send_frame(vecs[2], 1'b0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_deserializer.md
Name: frame_deserializer

Overview:
Downstream consumer of the serial sequence detector. It takes the payload bits the detector forwards after a header match and packs them MSB-first into WIDTH-bit words. Each word is presented on a registered single-entry valid/ready output. Frame start is taken from the detector's counter-reset pulse; per-bit validity is taken from its counter-increment strobe.

Parameters:
WIDTH, 8, payload word width in bits (>= 2)
CNT_W, 4, bit-counter width; must hold 0..WIDTH, i.e. clog2(WIDTH)+1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
clk_en  input  1  sampling enable, shared with the detector; gates the frame FSM and bit capture only
frm_start  input  1  frame-start pulse; wired to detector rst_cnt
bit_valid  input  1  payload bit present on ser_in; wired to detector inc_cnt
ser_in  input  1  payload bit; wired to detector ser_out
out_ready  input  1  consumer accepts out_data this edge
out_data  output  WIDTH  assembled word, first-received bit in the MSB
out_valid  output  1  out_data/out_last/out_nbits hold a word
out_last  output  1  word closes the frame
out_nbits  output  CNT_W  number of meaningful bits in out_data (0..WIDTH)
ovf  output  1  sticky: a word was dropped because the holding register was full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register=0; bit count=0.
  - out_data=0, out_valid=0, out_last=0, out_nbits=0, ovf=0, busy=0.
  - Takes effect immediately, including mid-frame. No partial word survives reset.
- The FSM and capture logic advance only on edges where clk_en=1. The output handshake is evaluated on every edge regardless of clk_en.
- FSM states:
  - IDLE:
    - frm_start=1 -> ARM; shift register and count cleared.
  - ARM:
    - frm_start=1 -> stay in ARM.
    - bit_valid=1 -> COLLECT, capturing the first bit (count=1).
    - otherwise stay in ARM.
  - COLLECT, in priority order:
    - frm_start=1 -> abort. Discard the partial word, clear the count, go to ARM. Nothing is pushed.
    - bit_valid=1 -> shift = {shift[WIDTH-2:0], ser_in}; count++. If count becomes WIDTH, push the word with nbits=WIDTH and last=0, then set count=0.
    - bit_valid=0 (frame end):
      - If count>0, push the partial word right-justified: the low count bits hold the data in arrival order, upper bits are 0, nbits=count, last=1.
      - If count=0, push a terminator: data=0, nbits=0, last=1.
      - Then go to IDLE.
- Push timing: a push loads the output registers on the same edge that samples the completing bit or the frame end. out_valid is visible in the following cycle, so latency is 1 edge.
- Handshake:
  - Consumption happens when out_valid=1 and out_ready=1 at an edge; out_valid clears unless a push occurs on that same edge.
  - A push with the register empty, or being consumed on the same edge, loads the new word and sets out_valid=1.
  - A push while out_valid=1 and out_ready=0 drops the new word; the held word is unchanged and ovf is set.
  - ovf clears only on reset.
- Held outputs stay stable while out_valid=1 and out_ready=0.
- busy = (state != IDLE). It is combinational from the registered state.
- Every frame, including an empty one, produces exactly one out_last=1 word unless the frame is aborted or reset.

Test Plan:
1. WIDTH=8, clk_en=1, out_ready=1, frm_start for 1 cycle, then 16 bits of bit_valid carrying 0xA5 then 0x3C MSB-first, then bit_valid=0 -> expect three words:
   - 0xA5 with nbits=8, last=0;
   - 0x3C with nbits=8, last=0;
   - data=0x00 with nbits=0, last=1, appearing 1 cycle after bit_valid falls;
   - busy=0 afterwards; ovf=0.
2. Frame of 11 bits, 0xF0 followed by 1,0,1 -> expect 0xF0 (nbits=8, last=0), then 0x05 (nbits=3, last=1).
3. out_ready=0 throughout a 16-bit frame -> expect:
   - out_valid=1 with 0xA5 held;
   - ovf=1 after the 16th bit;
   - raising out_ready shows 0xA5 was never overwritten.
4. Case 1 repeated with clk_en alternating 1/0 and each bit held for 2 cycles -> identical word sequence; nothing is sampled on clk_en=0 edges.
5. rst driven low after 5 payload bits -> all outputs 0 immediately and busy=0. A following 8-bit frame of 0x81 yields 0x81 then the terminator.
6. frm_start reasserted after 4 bits in COLLECT -> no word is emitted; the next 8 bits 0x3C produce 0x3C with nbits=8.
